log2_iter: RTL and testbench

- Parametrised iterative fixed-point base-2 logarithm unit; successor to the fixed-width normaliser.
- Takes an unsigned Q(IW.FW) operand and normalises it to a mantissa in [1,2), counting the integer characteristic.
- Extracts OFW fractional result bits by repeated squaring, one bit per cycle.
- Returns a signed Q(CW.OFW) result behind a start/busy/done handshake, with an error flag for zero input.

---
 rtl/log2_iter.sv | 150 +++++++++++++++
 tb/tb_log2_iter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/log2_iter.sv
// log2_iter: iterative fixed-point base-2 logarithm.
// The unsigned Q(IW.FW) operand is normalised to a Q1.(N-1) mantissa in [1,2).
// Each leading zero that is shifted out lowers the integer characteristic by one.
// The fraction is then produced one bit per cycle by repeated squaring.
// The signed Q(CW.OFW) result and the zero-input error flag stay registered
// until the next operation is accepted.
module log2_iter #(
    parameter int  IW  = 8,
    parameter int  FW  = 8,
    parameter int  OFW = 8,
    localparam int N   = IW + FW,
    // The characteristic spans IW-1 down to -FW. This many signed bits covers both ends.
    localparam int CW  = $clog2((IW > FW) ? IW : FW) + 1,
    localparam int RW  = CW + OFW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [N-1:0]  a,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [RW-1:0] result
);

    localparam int SW = $clog2(N) + 1;
    localparam int JW = $clog2(OFW) + 1;
    localparam logic [RW-1:0] MOST_NEG = {1'b1, {(RW-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        FRAC = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  m_q, m_d;
    logic [SW-1:0] s_q, s_d;
    logic [JW-1:0] j_q, j_d;
    logic [CW-1:0] k_q, k_d;
    logic [OFW-1:0] frac_q, frac_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [RW-1:0] result_q, result_d;

    // Top N+1 bits of the Q2.(2N-2) square. The low bits are discarded by truncation.
    logic [N:0]    sq_hi;
    logic [N-2:0]  unused_sq_lo;

    // Square the mantissa, then decide the next state, counters and outputs.
    always_comb begin
        {sq_hi, unused_sq_lo} = {{N{1'b0}}, m_q} * {{N{1'b0}}, m_q};

        state_d  = state_q;
        m_d      = m_q;
        s_d      = s_q;
        j_d      = j_q;
        k_d      = k_q;
        frac_d   = frac_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                // While done is still showing, block a new accept. A held start is
                // then taken on the following cycle.
                if (start && !done_q) begin
                    busy_d = 1'b1;
                    if (a != '0) begin
                        m_d     = a;
                        s_d     = '0;
                        err_d   = 1'b0;
                        state_d = NORM;
                    end else begin
                        err_d    = 1'b1;
                        result_d = MOST_NEG;
                        state_d  = DONE;
                    end
                end
            end
            NORM: begin
                if (m_q[N-1]) begin
                    // Wrap-around arithmetic is exact because the true k fits in CW bits.
                    k_d     = CW'(IW - 1) - CW'(s_q);
                    j_d     = '0;
                    frac_d  = '0;
                    state_d = FRAC;
                end else begin
                    m_d = m_q << 1;
                    s_d = s_q + 1'b1;
                end
            end
            FRAC: begin
                // When the square is 2.0 or more, emit a 1 and halve it back into [1,2).
                frac_d = {frac_q[OFW-2:0], sq_hi[N]};
                m_d    = sq_hi[N] ? sq_hi[N:1] : sq_hi[N-1:0];
                j_d    = j_q + 1'b1;
                if (j_q == JW'(OFW - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d = 1'b1;
                busy_d = 1'b0;
                if (!err_q) begin
                    result_d = {k_q, frac_q};
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Register all state. An active-low synchronous reset clears everything.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            m_q      <= '0;
            s_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            frac_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            m_q      <= m_d;
            s_q      <= s_d;
            j_q      <= j_d;
            k_q      <= k_d;
            frac_q   <= frac_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            result_q <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign result = result_q;

endmodule

// File: tb/tb_log2_iter.sv
// Testbench for log2_iter.
// The stimulus process pushes the expected response for each operation into a queue.
// A monitor process pops from that queue and compares every time done pulses.
module tb_log2_iter;

    localparam int IW  = 8;
    localparam int FW  = 8;
    localparam int OFW = 8;
    localparam int N   = IW + FW;
    localparam int CW  = 4;
    localparam int RW  = CW + OFW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [N-1:0]  a = '0;
    logic          busy;
    logic          done;
    logic          err;
    logic [RW-1:0] result;

    typedef struct {
        logic [RW-1:0] res;
        bit            e;
        int            acc;
        int            lat;
        logic [N-1:0]  av;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    log2_iter #(.IW(IW), .FW(FW), .OFW(OFW)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .result (result)
    );

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model, built directly from the arithmetic definition.
    // The characteristic is the MSB position minus FW.
    // The fraction bits come from repeatedly squaring the mantissa value in [1,2),
    // truncated to N-1 fraction bits.
    function automatic void model(input logic [N-1:0] av, output logic [RW-1:0] r,
                                  output bit e, output int lat);
        int     p;
        int     k;
        longint mant;
        longint sq;
        longint fr;
        longint full;
        if (av == '0) begin
            r   = {1'b1, {(RW-1){1'b0}}};
            e   = 1'b1;
            lat = 1;
            return;
        end
        p = 0;
        for (int i = 0; i < N; i++) if (av[i]) p = i;
        k    = p - FW;
        mant = longint'(av) << (N - 1 - p);
        fr   = 0;
        for (int i = 0; i < OFW; i++) begin
            sq = mant * mant;
            fr = fr * 2;
            if (sq >= (longint'(1) << (2 * N - 1))) begin
                fr   = fr + 1;
                mant = sq >> N;
            end else begin
                mant = sq >> (N - 1);
            end
        end
        full = longint'(k) * (longint'(1) << OFW) + fr;
        r    = full[RW-1:0];
        e    = 1'b0;
        lat  = (N - 1 - p) + OFW + 2;
    endfunction

    task automatic push_exp(input logic [N-1:0] av, input bit use_tab,
                            input logic [RW-1:0] tres, input bit terr, input int acc);
        exp_t x;
        logic [RW-1:0] mr;
        bit me;
        int ml;
        model(av, mr, me, ml);
        x.res = use_tab ? tres : mr;
        x.e   = use_tab ? terr : me;
        x.acc = acc;
        x.lat = ml;
        x.av  = av;
        sbq.push_back(x);
    endtask

    // Assert start for one cycle with operand av. Then scramble a, which must not affect the result.
    task automatic issue(input logic [N-1:0] av, input bit use_tab,
                         input logic [RW-1:0] tres, input bit terr);
        @(negedge clk);
        start = 1'b1;
        a     = av;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = N'($urandom);
        push_exp(av, use_tab, tres, terr, cyc);
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL done_timeout actual=no done required=done within %0d cycles", budget);
        end
    endtask

    // Monitor: compare every done pulse against the next queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done actual=done result=%03h required=no done", result);
                end else begin
                    e = sbq.pop_front();
                    check("result", longint'(result), longint'(e.res));
                    check("err", longint'(err), longint'(e.e));
                    check("latency", longint'(cyc - e.acc), longint'(e.lat));
                    check("busy_at_done", longint'(busy), 0);
                    $display("txn a=%04h result=%03h err=%0d latency=%0d", e.av, result, err, cyc - e.acc);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    logic [N-1:0]  tab_a   [8] = '{16'h0100, 16'h0200, 16'h0080, 16'h0003,
                                  16'hFFFF, 16'h0001, 16'h0000, 16'h0100};
    logic [RW-1:0] tab_res [8] = '{12'h000, 12'h100, 12'hF00, 12'h995,
                                  12'h7FF, 12'h800, 12'h800, 12'h000};
    bit            tab_err [8] = '{0, 0, 0, 0, 0, 0, 1, 0};

    initial begin
        int d_acc;
        logic [N-1:0] av;

        // Reset state
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", longint'(busy), 0);
        check("reset_done", longint'(done), 0);
        check("reset_err", longint'(err), 0);
        check("reset_result", longint'(result), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Directed cases with tabulated expectations
        for (int i = 0; i < 8; i++) begin
            issue(tab_a[i], 1'b1, tab_res[i], tab_err[i]);
            wait_done(100);
            if (tab_a[i] == '0) begin
                repeat (3) @(negedge clk);
                check("err_held", longint'(err), 1);
                check("result_held", longint'(result), longint'(12'h800));
            end
        end

        // start held high across two operations: there is exactly one done per operation,
        // and the second operation is accepted two edges after done rises.
        @(negedge clk);
        start = 1'b1;
        a     = 16'h0100;
        @(posedge clk);
        #1;
        push_exp(16'h0100, 1'b1, 12'h000, 1'b0, cyc);
        wait_done(100);
        a = 16'h0200;
        d_acc = cyc + 2;
        push_exp(16'h0200, 1'b1, 12'h100, 1'b0, d_acc);
        wait_done(100);
        start = 1'b0;
        repeat (30) @(negedge clk);

        // Reset in the middle of FRAC discards the in-flight operation.
        issue(16'h0100, 1'b1, 12'h000, 1'b0);
        repeat (12) @(negedge clk);
        rst = 1'b0;
        sbq.delete();
        @(negedge clk);
        check("midrst_busy", longint'(busy), 0);
        check("midrst_done", longint'(done), 0);
        check("midrst_err", longint'(err), 0);
        check("midrst_result", longint'(result), 0);
        rst = 1'b1;
        repeat (25) @(negedge clk);
        issue(16'h0003, 1'b1, 12'h995, 1'b0);
        wait_done(100);

        // Randomised operands with a spread of leading-zero counts, occasionally zero.
        for (int i = 0; i < 40; i++) begin
            av = N'($urandom_range(0, 65535) >> $urandom_range(0, 16));
            issue(av, 1'b0, '0, 1'b0);
            wait_done(100);
        end

        repeat (5) @(negedge clk);
        check("queue_drained", longint'(sbq.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
